fpu_cmp_issue: RTL and testbench

- Initiator/sequencer on the request side of the FPU compare datapath (FEQ/FLT/FLE/FMIN/FMAX).
- Accepts one compare instruction from dispatch via valid/ready and applies RISC-V NaN-boxing to SP operands.
- Drives the combinational compare core, registers its result, then formats and returns it to the writeback arbiter (integer RF for FEQ/FLT/FLE, FP RF for FMIN/FMAX).
- Fixes up the NV flag for FMIN/FMAX with sNaN and keeps a sticky NV accrued flag.

---
 rtl/fpu_cmp_issue.sv | 194 +++++++++++++++++++
 tb/tb_fpu_cmp_issue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cmp_issue.sv
// Issue/sequencer stage for the FPU compare core (FEQ/FLT/FLE/FMIN/FMAX).
// Accepts one op, NaN-boxes SP operands, runs the core for one cycle, then
// holds the formatted result for the writeback arbiter.
module fpu_cmp_issue #(
    parameter int unsigned RD_W = 5
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            FLUSH,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [2:0]      REQ_OP,
    input  logic            REQ_SP_DP,
    input  logic [63:0]     REQ_RS1,
    input  logic [63:0]     REQ_RS2,
    input  logic [RD_W-1:0] REQ_RD,
    output logic [63:0]     CMP_INPUT_1,
    output logic [63:0]     CMP_INPUT_2,
    output logic            CMP_SP_DP,
    output logic [2:0]      CMP_OPERATION,
    input  logic [63:0]     CMP_OUTPUT,
    input  logic            CMP_INVALID,
    output logic            WB_VALID,
    input  logic            WB_READY,
    output logic [63:0]     WB_DATA,
    output logic [RD_W-1:0] WB_RD,
    output logic            WB_TO_INT,
    output logic            WB_NV,
    output logic            WB_ILLEGAL,
    input  logic            FFLAGS_CLR,
    output logic            FFLAGS_NV
);

    localparam int unsigned DATA_W  = 64;
    localparam logic [DATA_W-1:0] SP_QNAN = 64'h0000_0000_7FC0_0000;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic              sp_dp_q, sp_dp_d;
    logic [2:0]        op_q, op_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic              wb_to_int_q, wb_to_int_d;
    logic              wb_nv_q, wb_nv_d;
    logic              wb_illegal_q, wb_illegal_d;
    logic              fflags_nv_q, fflags_nv_d;

    logic              req_ready_c;
    logic              accept_c;
    logic              wb_fire_c;

    // Signalling NaN at the selected precision: exp all ones, quiet bit 0, mantissa nonzero
    function automatic logic is_snan(input logic [DATA_W-1:0] v, input logic dp);
        if (dp) return (&v[62:52]) & ~v[51] & (|v[50:0]);
        else    return (&v[30:23]) & ~v[22] & (|v[21:0]);
    endfunction

    // Unboxed SP operands are replaced by the canonical quiet NaN
    function automatic logic [DATA_W-1:0] nan_box(input logic [DATA_W-1:0] v, input logic dp);
        if (!dp && (v[63:32] != 32'hFFFF_FFFF)) return SP_QNAN;
        else                                     return v;
    endfunction

    // Ready and handshake qualifiers
    always_comb begin
        req_ready_c = !FLUSH && ((state_q == IDLE) || ((state_q == HOLD) && WB_READY));
        accept_c    = REQ_VALID && req_ready_c;
        wb_fire_c   = wb_valid_q && WB_READY;
    end

    // Next-state, operand latching and result formatting
    always_comb begin
        state_d      = state_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        sp_dp_d      = sp_dp_q;
        op_d         = op_q;
        rd_d         = rd_q;
        wb_valid_d   = wb_valid_q;
        wb_data_d    = wb_data_q;
        wb_rd_d      = wb_rd_q;
        wb_to_int_d  = wb_to_int_q;
        wb_nv_d      = wb_nv_q;
        wb_illegal_d = wb_illegal_q;

        if (accept_c) begin
            rs1_d   = nan_box(REQ_RS1, REQ_SP_DP);
            rs2_d   = nan_box(REQ_RS2, REQ_SP_DP);
            sp_dp_d = REQ_SP_DP;
            op_d    = REQ_OP;
            rd_d    = REQ_RD;
        end

        case (state_q)
            IDLE: begin
                if (accept_c) state_d = EXEC;
            end
            EXEC: begin
                if (FLUSH) begin
                    state_d = IDLE;
                end else begin
                    state_d      = HOLD;
                    wb_valid_d   = 1'b1;
                    wb_rd_d      = rd_q;
                    wb_illegal_d = 1'b0;
                    case (op_q)
                        3'b000, 3'b001, 3'b010: begin
                            wb_to_int_d = 1'b1;
                            wb_data_d   = {63'b0, CMP_OUTPUT[0]};
                            wb_nv_d     = CMP_INVALID;
                        end
                        3'b100, 3'b101: begin
                            wb_to_int_d = 1'b0;
                            wb_data_d   = sp_dp_q ? CMP_OUTPUT : {32'hFFFF_FFFF, CMP_OUTPUT[31:0]};
                            wb_nv_d     = CMP_INVALID | is_snan(rs1_q, sp_dp_q) | is_snan(rs2_q, sp_dp_q);
                        end
                        default: begin
                            wb_to_int_d  = 1'b1;
                            wb_data_d    = '0;
                            wb_nv_d      = 1'b0;
                            wb_illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            HOLD: begin
                if (FLUSH) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b0;
                end else if (wb_fire_c) begin
                    wb_valid_d = 1'b0;
                    state_d    = accept_c ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Set on an NV writeback takes priority over software clear
        if (wb_fire_c && wb_nv_q) fflags_nv_d = 1'b1;
        else if (FFLAGS_CLR)      fflags_nv_d = 1'b0;
        else                      fflags_nv_d = fflags_nv_q;
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            rs1_q        <= '0;
            rs2_q        <= '0;
            sp_dp_q      <= 1'b0;
            op_q         <= '0;
            rd_q         <= '0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_rd_q      <= '0;
            wb_to_int_q  <= 1'b0;
            wb_nv_q      <= 1'b0;
            wb_illegal_q <= 1'b0;
            fflags_nv_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            sp_dp_q      <= sp_dp_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            wb_valid_q   <= wb_valid_d;
            wb_data_q    <= wb_data_d;
            wb_rd_q      <= wb_rd_d;
            wb_to_int_q  <= wb_to_int_d;
            wb_nv_q      <= wb_nv_d;
            wb_illegal_q <= wb_illegal_d;
            fflags_nv_q  <= fflags_nv_d;
        end
    end

    assign REQ_READY     = req_ready_c;
    assign CMP_INPUT_1   = rs1_q;
    assign CMP_INPUT_2   = rs2_q;
    assign CMP_SP_DP     = sp_dp_q;
    assign CMP_OPERATION = op_q;
    assign WB_VALID      = wb_valid_q;
    assign WB_DATA       = wb_data_q;
    assign WB_RD         = wb_rd_q;
    assign WB_TO_INT     = wb_to_int_q;
    assign WB_NV         = wb_nv_q;
    assign WB_ILLEGAL    = wb_illegal_q;
    assign FFLAGS_NV     = fflags_nv_q;

endmodule

// File: tb/tb_fpu_cmp_issue.sv
// Directed bench for fpu_cmp_issue; the compare core is stood in for by
// hand-chosen CMP_OUTPUT/CMP_INVALID values.
module tb_fpu_cmp_issue;

    localparam int unsigned RD_W = 5;

    logic            CLK, RST_N, FLUSH;
    logic            REQ_VALID, REQ_READY;
    logic [2:0]      REQ_OP;
    logic            REQ_SP_DP;
    logic [63:0]     REQ_RS1, REQ_RS2;
    logic [RD_W-1:0] REQ_RD;
    logic [63:0]     CMP_INPUT_1, CMP_INPUT_2;
    logic            CMP_SP_DP;
    logic [2:0]      CMP_OPERATION;
    logic [63:0]     CMP_OUTPUT;
    logic            CMP_INVALID;
    logic            WB_VALID, WB_READY;
    logic [63:0]     WB_DATA;
    logic [RD_W-1:0] WB_RD;
    logic            WB_TO_INT, WB_NV, WB_ILLEGAL;
    logic            FFLAGS_CLR, FFLAGS_NV;

    int nvec = 0;
    int nerr = 0;

    fpu_cmp_issue #(.RD_W(RD_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_SP_DP(REQ_SP_DP), .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2), .REQ_RD(REQ_RD),
        .CMP_INPUT_1(CMP_INPUT_1), .CMP_INPUT_2(CMP_INPUT_2), .CMP_SP_DP(CMP_SP_DP),
        .CMP_OPERATION(CMP_OPERATION), .CMP_OUTPUT(CMP_OUTPUT), .CMP_INVALID(CMP_INVALID),
        .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_DATA(WB_DATA), .WB_RD(WB_RD),
        .WB_TO_INT(WB_TO_INT), .WB_NV(WB_NV), .WB_ILLEGAL(WB_ILLEGAL),
        .FFLAGS_CLR(FFLAGS_CLR), .FFLAGS_NV(FFLAGS_NV)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic dp, input logic [63:0] a,
                             input logic [63:0] b, input logic [RD_W-1:0] rd);
        REQ_VALID = 1'b1; REQ_OP = op; REQ_SP_DP = dp;
        REQ_RS1 = a; REQ_RS2 = b; REQ_RD = rd;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; FLUSH = 1'b0; REQ_VALID = 1'b0; REQ_OP = '0; REQ_SP_DP = 1'b0;
        REQ_RS1 = '0; REQ_RS2 = '0; REQ_RD = '0; CMP_OUTPUT = '0; CMP_INVALID = 1'b0;
        WB_READY = 1'b1; FFLAGS_CLR = 1'b0;
        #3;
        nvec++; if (WB_VALID !== 1'b0) begin nerr++; $display("FAIL rst_wb_valid got %b want 0", WB_VALID); end
        nvec++; if (WB_DATA !== 64'h0) begin nerr++; $display("FAIL rst_wb_data got %h want 0", WB_DATA); end
        nvec++; if ({WB_RD, WB_TO_INT, WB_NV, WB_ILLEGAL, FFLAGS_NV} !== '0) begin nerr++; $display("FAIL rst_wb_flags got %b want 0", {WB_RD, WB_TO_INT, WB_NV, WB_ILLEGAL, FFLAGS_NV}); end
        nvec++; if ({CMP_INPUT_1, CMP_INPUT_2, CMP_SP_DP, CMP_OPERATION} !== '0) begin nerr++; $display("FAIL rst_cmp got %h want 0", {CMP_INPUT_1, CMP_INPUT_2, CMP_SP_DP, CMP_OPERATION}); end
        @(negedge CLK); RST_N = 1'b1;
        tick();
        nvec++; if (REQ_READY !== 1'b1) begin nerr++; $display("FAIL rst_req_ready got %b want 1", REQ_READY); end
    endtask

    task automatic test_dp_flt();
        drive_req(3'b001, 1'b1, 64'hBFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 5'd3);
        CMP_OUTPUT = 64'h1; CMP_INVALID = 1'b0; WB_READY = 1'b1;
        #1;
        nvec++; if (REQ_READY !== 1'b1) begin nerr++; $display("FAIL flt_ready got %b want 1", REQ_READY); end
        tick(); REQ_VALID = 1'b0;
        nvec++; if (WB_VALID !== 1'b0) begin nerr++; $display("FAIL flt_n1_valid got %b want 0", WB_VALID); end
        nvec++; if (CMP_INPUT_1 !== 64'hBFF0_0000_0000_0000 || CMP_INPUT_2 !== 64'h3FF0_0000_0000_0000) begin nerr++; $display("FAIL flt_cmp_in got %h %h want bff0.. 3ff0..", CMP_INPUT_1, CMP_INPUT_2); end
        nvec++; if (CMP_OPERATION !== 3'b001 || CMP_SP_DP !== 1'b1) begin nerr++; $display("FAIL flt_cmp_op got %b %b want 001 1", CMP_OPERATION, CMP_SP_DP); end
        tick();
        nvec++; if (WB_VALID !== 1'b1) begin nerr++; $display("FAIL flt_n2_valid got %b want 1", WB_VALID); end
        nvec++; if (WB_DATA !== 64'h1 || WB_TO_INT !== 1'b1 || WB_NV !== 1'b0 || WB_RD !== 5'd3 || WB_ILLEGAL !== 1'b0) begin nerr++; $display("FAIL flt_result got data=%h int=%b nv=%b rd=%0d ill=%b want 1 1 0 3 0", WB_DATA, WB_TO_INT, WB_NV, WB_RD, WB_ILLEGAL); end
        tick();
        nvec++; if (WB_VALID !== 1'b0 || FFLAGS_NV !== 1'b0) begin nerr++; $display("FAIL flt_after got valid=%b nv=%b want 0 0", WB_VALID, FFLAGS_NV); end
    endtask

    task automatic test_sp_fmin_boxing();
        drive_req(3'b100, 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_4000_0000, 5'd10);
        CMP_OUTPUT = 64'hDEAD_BEEF_4000_0000; CMP_INVALID = 1'b0;
        tick(); REQ_VALID = 1'b0;
        nvec++; if (CMP_INPUT_1 !== 64'h0000_0000_7FC0_0000) begin nerr++; $display("FAIL fmin_box1 got %h want 000000007fc00000", CMP_INPUT_1); end
        nvec++; if (CMP_INPUT_2 !== 64'hFFFF_FFFF_4000_0000 || CMP_SP_DP !== 1'b0) begin nerr++; $display("FAIL fmin_box2 got %h sp_dp=%b want ffffffff40000000 0", CMP_INPUT_2, CMP_SP_DP); end
        tick();
        nvec++; if (WB_DATA !== 64'hFFFF_FFFF_4000_0000 || WB_TO_INT !== 1'b0 || WB_NV !== 1'b0) begin nerr++; $display("FAIL fmin_result got %h int=%b nv=%b want ffffffff40000000 0 0", WB_DATA, WB_TO_INT, WB_NV); end
        tick();
    endtask

    task automatic test_dp_snan_fflags();
        drive_req(3'b101, 1'b1, 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 5'd1);
        CMP_OUTPUT = 64'h7FF8_0000_0000_0000; CMP_INVALID = 1'b0;
        tick(); REQ_VALID = 1'b0;
        tick();
        nvec++; if (WB_NV !== 1'b1 || WB_DATA !== 64'h7FF8_0000_0000_0000 || WB_TO_INT !== 1'b0) begin nerr++; $display("FAIL fmax_snan got nv=%b data=%h int=%b want 1 7ff8000000000000 0", WB_NV, WB_DATA, WB_TO_INT); end
        nvec++; if (FFLAGS_NV !== 1'b0) begin nerr++; $display("FAIL fflags_pre got %b want 0", FFLAGS_NV); end
        tick();
        nvec++; if (FFLAGS_NV !== 1'b1) begin nerr++; $display("FAIL fflags_set got %b want 1", FFLAGS_NV); end
        drive_req(3'b000, 1'b1, 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 5'd2);
        CMP_OUTPUT = 64'h0; CMP_INVALID = 1'b1;
        tick(); REQ_VALID = 1'b0;
        tick();
        nvec++; if (WB_NV !== 1'b1 || WB_DATA !== 64'h0 || WB_TO_INT !== 1'b1) begin nerr++; $display("FAIL feq_nv got nv=%b data=%h int=%b want 1 0 1", WB_NV, WB_DATA, WB_TO_INT); end
        FFLAGS_CLR = 1'b1;
        tick(); FFLAGS_CLR = 1'b0;
        nvec++; if (FFLAGS_NV !== 1'b1) begin nerr++; $display("FAIL fflags_set_vs_clr got %b want 1", FFLAGS_NV); end
        FFLAGS_CLR = 1'b1;
        tick(); FFLAGS_CLR = 1'b0;
        nvec++; if (FFLAGS_NV !== 1'b0) begin nerr++; $display("FAIL fflags_clr got %b want 0", FFLAGS_NV); end
    endtask

    task automatic test_sp_snan();
        drive_req(3'b100, 1'b0, 64'hFFFF_FFFF_7F80_0001, 64'hFFFF_FFFF_3F80_0000, 5'd11);
        CMP_OUTPUT = 64'h0000_0000_3F80_0000; CMP_INVALID = 1'b0;
        tick(); REQ_VALID = 1'b0;
        tick();
        nvec++; if (WB_NV !== 1'b1 || WB_DATA !== 64'hFFFF_FFFF_3F80_0000) begin nerr++; $display("FAIL sp_snan got nv=%b data=%h want 1 ffffffff3f800000", WB_NV, WB_DATA); end
        tick();
        FFLAGS_CLR = 1'b1;
        tick(); FFLAGS_CLR = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive_req(3'b010, 1'b0, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_3F80_0000, 5'd7);
        CMP_OUTPUT = 64'h1; CMP_INVALID = 1'b0; WB_READY = 1'b0;
        tick();
        drive_req(3'b000, 1'b1, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 5'd9);
        tick();
        CMP_OUTPUT = 64'h0;
        for (int i = 0; i < 3; i++) begin
            nvec++; if (WB_VALID !== 1'b1 || WB_DATA !== 64'h1 || WB_RD !== 5'd7 || WB_TO_INT !== 1'b1) begin nerr++; $display("FAIL stall_%0d got v=%b data=%h rd=%0d want 1 1 7", i, WB_VALID, WB_DATA, WB_RD); end
            nvec++; if (REQ_READY !== 1'b0) begin nerr++; $display("FAIL stall_ready_%0d got %b want 0", i, REQ_READY); end
            tick();
        end
        WB_READY = 1'b1;
        #1;
        nvec++; if (REQ_READY !== 1'b1) begin nerr++; $display("FAIL b2b_ready got %b want 1", REQ_READY); end
        tick(); REQ_VALID = 1'b0;
        nvec++; if (WB_VALID !== 1'b0 || CMP_INPUT_1 !== 64'h4000_0000_0000_0000 || CMP_OPERATION !== 3'b000) begin nerr++; $display("FAIL b2b_exec got v=%b in1=%h op=%b want 0 4000000000000000 000", WB_VALID, CMP_INPUT_1, CMP_OPERATION); end
        tick();
        nvec++; if (WB_VALID !== 1'b1 || WB_RD !== 5'd9 || WB_DATA !== 64'h0) begin nerr++; $display("FAIL b2b_result got v=%b rd=%0d data=%h want 1 9 0", WB_VALID, WB_RD, WB_DATA); end
        tick();
    endtask

    task automatic test_illegal();
        drive_req(3'b111, 1'b1, 64'h7FF0_0000_0000_0001, 64'h1, 5'd6);
        CMP_OUTPUT = 64'hFFFF_FFFF_FFFF_FFFF; CMP_INVALID = 1'b1;
        tick(); REQ_VALID = 1'b0;
        tick();
        nvec++; if (WB_ILLEGAL !== 1'b1 || WB_DATA !== 64'h0 || WB_NV !== 1'b0 || WB_TO_INT !== 1'b1 || WB_RD !== 5'd6) begin nerr++; $display("FAIL illegal got ill=%b data=%h nv=%b int=%b rd=%0d want 1 0 0 1 6", WB_ILLEGAL, WB_DATA, WB_NV, WB_TO_INT, WB_RD); end
        tick();
        nvec++; if (FFLAGS_NV !== 1'b0) begin nerr++; $display("FAIL illegal_fflags got %b want 0", FFLAGS_NV); end
    endtask

    task automatic test_flush();
        drive_req(3'b000, 1'b1, 64'h1, 64'h2, 5'd4);
        CMP_OUTPUT = 64'h1; CMP_INVALID = 1'b1;
        tick();
        FLUSH = 1'b1;
        #1;
        nvec++; if (REQ_READY !== 1'b0) begin nerr++; $display("FAIL flush_ready got %b want 0", REQ_READY); end
        tick(); FLUSH = 1'b0; REQ_VALID = 1'b0;
        nvec++; if (WB_VALID !== 1'b0) begin nerr++; $display("FAIL flush_valid got %b want 0", WB_VALID); end
        #1;
        nvec++; if (REQ_READY !== 1'b1) begin nerr++; $display("FAIL flush_idle_ready got %b want 1", REQ_READY); end
        tick();
        nvec++; if (WB_VALID !== 1'b0 || FFLAGS_NV !== 1'b0) begin nerr++; $display("FAIL flush_discard got v=%b nv=%b want 0 0", WB_VALID, FFLAGS_NV); end
        // Writeback handshake coinciding with FLUSH still completes
        drive_req(3'b001, 1'b1, 64'h1, 64'h2, 5'd5);
        tick(); REQ_VALID = 1'b0;
        tick();
        FLUSH = 1'b1;
        tick(); FLUSH = 1'b0;
        nvec++; if (WB_VALID !== 1'b0 || FFLAGS_NV !== 1'b1) begin nerr++; $display("FAIL flush_hs got v=%b nv=%b want 0 1", WB_VALID, FFLAGS_NV); end
    endtask

    task automatic test_reset_mid_op();
        drive_req(3'b101, 1'b1, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 5'd12);
        CMP_OUTPUT = 64'h4000_0000_0000_0000; CMP_INVALID = 1'b0; WB_READY = 1'b0;
        tick(); REQ_VALID = 1'b0;
        tick();
        nvec++; if (WB_VALID !== 1'b1 || WB_RD !== 5'd12) begin nerr++; $display("FAIL pre_rst got v=%b rd=%0d want 1 12", WB_VALID, WB_RD); end
        RST_N = 1'b0;
        #1;
        nvec++; if (WB_VALID !== 1'b0 || WB_DATA !== 64'h0 || WB_RD !== '0 || WB_TO_INT !== 1'b0) begin nerr++; $display("FAIL mid_rst_wb got v=%b data=%h rd=%0d int=%b want 0 0 0 0", WB_VALID, WB_DATA, WB_RD, WB_TO_INT); end
        nvec++; if (FFLAGS_NV !== 1'b0 || CMP_INPUT_1 !== 64'h0 || CMP_OPERATION !== 3'b000 || CMP_SP_DP !== 1'b0) begin nerr++; $display("FAIL mid_rst_misc got nv=%b in1=%h op=%b dp=%b want 0 0 0 0", FFLAGS_NV, CMP_INPUT_1, CMP_OPERATION, CMP_SP_DP); end
        @(negedge CLK); RST_N = 1'b1; WB_READY = 1'b1;
        tick();
        nvec++; if (REQ_READY !== 1'b1 || WB_VALID !== 1'b0) begin nerr++; $display("FAIL post_rst got ready=%b v=%b want 1 0", REQ_READY, WB_VALID); end
    endtask

    initial begin
        test_reset();
        test_dp_flt();
        test_sp_fmin_boxing();
        test_dp_snan_fflags();
        test_sp_snan();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
